// File: rtl/ioc_dispatch.sv
// ioc_dispatch: turns host command/data bytes into IOC module load/fetch
// strobes and returns one response byte per read, with timeout and sticky errors.
//
// Ports:
//   i_sys_clk, i_rst            clock, async active-high reset
//   i_frame_start               new host transaction begins
//   i_byte_valid, i_byte        host byte stream
//   o_cs, o_ioc, o_data_out     one-hot module select, IOC address, write data
//   o_load_cmd, o_fetch_cmd     write / read strobes
//   i_rd_data, i_rd_valid       per-module read data (byte m) and valid
//   o_resp_valid, o_resp_byte   response pulse and byte to host
//   o_busy                      not idle
//   i_err_clear, o_error_list   sticky errors: [0] timeout, [1] dropped byte,
//                               [2] aborted frame
module ioc_dispatch #(
  parameter int NUM_MOD = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte,
  output logic [NUM_MOD-1:0]   o_cs,
  output logic [4:0]           o_ioc,
  output logic [7:0]           o_data_out,
  output logic                 o_load_cmd,
  output logic                 o_fetch_cmd,
  input  logic [8*NUM_MOD-1:0] i_rd_data,
  input  logic [NUM_MOD-1:0]   i_rd_valid,
  output logic                 o_resp_valid,
  output logic [7:0]           o_resp_byte,
  output logic                 o_busy,
  input  logic                 i_err_clear,
  output logic [7:0]           o_error_list
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_LOAD,
    S_FETCH,
    S_WAIT_RD,
    S_RESP
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);
  localparam logic [NUM_MOD-1:0] ONE = NUM_MOD'(1);

  state_t               r_state;
  logic [NUM_MOD-1:0]   r_cs;
  logic [4:0]           r_ioc;
  logic [1:0]           r_mod;
  logic [7:0]           r_data;
  logic                 r_load;
  logic                 r_fetch;
  logic                 r_resp_v;
  logic [7:0]           r_resp;
  logic [7:0]           r_cnt;
  logic [2:0]           r_err;
  logic                 r_pend;
  logic [7:0]           r_pend_byte;

  logic                 w_abort;
  logic                 w_drop;
  logic                 w_to;
  logic                 w_cmd_v;
  logic [7:0]           w_cmd;
  logic                 w_sel_v;
  logic [7:0]           w_sel_d;
  logic [7:0]           w_cnt_nx;

  assign w_sel_v  = i_rd_valid[r_mod];
  assign w_sel_d  = i_rd_data[{r_mod, 3'b000} +: 8];
  assign w_cnt_nx = r_cnt + 8'd1;

  // A command byte that arrived together with an aborting frame start
  // is parked in r_pend_byte and decoded on the following IDLE cycle.
  assign w_cmd_v = i_byte_valid | r_pend;
  assign w_cmd   = i_byte_valid ? i_byte : r_pend_byte;

  always_comb begin
    w_abort = 1'b0;
    w_drop  = 1'b0;
    w_to    = 1'b0;
    if (r_state != S_IDLE) begin
      w_abort = i_frame_start;
    end
    if (!i_frame_start && i_byte_valid) begin
      w_drop = (r_state == S_LOAD) || (r_state == S_FETCH) ||
               (r_state == S_WAIT_RD) || (r_state == S_RESP);
    end
    if (!i_frame_start && r_state == S_WAIT_RD && !w_sel_v) begin
      w_to = (w_cnt_nx == TO);
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cs        <= '0;
      r_ioc       <= '0;
      r_mod       <= '0;
      r_data      <= '0;
      r_load      <= 1'b0;
      r_fetch     <= 1'b0;
      r_resp_v    <= 1'b0;
      r_resp      <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_byte <= '0;
    end else begin
      r_load   <= 1'b0;
      r_fetch  <= 1'b0;
      r_resp_v <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_cs        <= '0;
        r_pend      <= i_byte_valid;
        r_pend_byte <= i_byte;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_cmd_v) begin
              r_pend <= 1'b0;
              r_ioc  <= w_cmd[4:0];
              r_mod  <= w_cmd[6:5];
              if (w_cmd[7]) begin
                r_state <= S_WAIT_DATA;
              end else begin
                r_state <= S_FETCH;
                r_cs    <= ONE << w_cmd[6:5];
                r_fetch <= 1'b1;
              end
            end
          end
          S_WAIT_DATA: begin
            if (i_byte_valid) begin
              r_data  <= i_byte;
              r_state <= S_LOAD;
              r_cs    <= ONE << r_mod;
              r_load  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_cs    <= '0;
            r_state <= S_IDLE;
          end
          S_FETCH: begin
            r_cnt   <= '0;
            r_state <= S_WAIT_RD;
          end
          S_WAIT_RD: begin
            if (w_sel_v) begin
              r_resp   <= w_sel_d;
              r_cs     <= '0;
              r_resp_v <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_cnt <= w_cnt_nx;
              if (w_to) begin
                r_resp   <= 8'hEE;
                r_cs     <= '0;
                r_resp_v <= 1'b1;
                r_state  <= S_RESP;
              end
            end
          end
          S_RESP: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_cs    <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // New error flags win over a coincident clear.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= '0;
    end else begin
      r_err <= (i_err_clear ? 3'b000 : r_err) | {w_abort, w_drop, w_to};
    end
  end

  assign o_cs         = r_cs;
  assign o_ioc        = r_ioc;
  assign o_data_out   = r_data;
  assign o_load_cmd   = r_load;
  assign o_fetch_cmd  = r_fetch;
  assign o_resp_valid = r_resp_v;
  assign o_resp_byte  = r_resp;
  assign o_busy       = (r_state != S_IDLE);
  assign o_error_list = {5'b00000, r_err};

endmodule
